// File: rtl/mic_sample_scheduler.sv
// -----------------------------------------------------------------------------
// mic_sample_scheduler
//
// Periodic sample scheduler for the MIC3 SPI microphone front end. A rate
// counter produces one tick every rate_div cycles. Each tick starts a
// conversion: mic_read is pulsed for READ_PULSE cycles, then the scheduler
// waits up to TIMEOUT cycles for mic_new_data. Captured samples are pushed
// into a first-word-fall-through FIFO that the consumer drains over a
// valid/ready handshake. Missed ticks, timeouts and overruns are sticky flags.
//
// Optional build macro: MIC_SCHED_SIGNED_EN
//   defined     - samples are converted from offset binary to two's
//                 complement (bit 11 inverted) before being stored
//   not defined - samples are stored unmodified
//
// Handshake: a sample transfers on every rising clk edge where
// sample_valid && sample_ready. sample_valid is high whenever the FIFO is not
// empty and sample_data holds the head sample; the head does not change
// until it has been accepted.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   enable        in   run; low = no new conversions started
//   rate_div      in   sample period in clk cycles, 0 = no ticks
//   clear_status  in   pulse; clears sticky flags and miss_cnt
//   mic_read      out  conversion request strobe (registered)
//   mic_new_data  in   conversion done pulse
//   mic_audio     in   conversion result, valid with mic_new_data
//   sample_data   out  FIFO head sample
//   sample_valid  out  FIFO not empty
//   sample_ready  in   consumer accepts the head sample
//   fifo_level    out  FIFO occupancy 0..DEPTH
//   overrun       out  sticky: sample dropped, FIFO full
//   timeout       out  sticky: conversion aborted after TIMEOUT cycles
//   missed        out  sticky: tick arrived during a conversion
//   miss_cnt      out  saturating count of missed ticks
// -----------------------------------------------------------------------------
module mic_sample_scheduler #(
   parameter int DEPTH      = 8,
   parameter int READ_PULSE = 2,
   parameter int TIMEOUT    = 4096,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic [15:0]   rate_div,
   input  logic          clear_status,
   output logic          mic_read,
   input  logic          mic_new_data,
   input  logic [11:0]   mic_audio,
   output logic [11:0]   sample_data,
   output logic          sample_valid,
   input  logic          sample_ready,
   output logic [AW:0]   fifo_level,
   output logic          overrun,
   output logic          timeout,
   output logic          missed,
   output logic [7:0]    miss_cnt
);

   localparam int PW = $clog2(READ_PULSE + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_TRIGGER   = 2'd1,
      S_WAIT_DATA = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [15:0]    div_cnt_q, div_cnt_d;
   logic [PW-1:0]  pulse_cnt_q, pulse_cnt_d;
   logic [TW-1:0]  to_cnt_q, to_cnt_d;
   logic           mic_read_q, mic_read_d;

   logic [11:0]    mem_q [DEPTH];
   logic [11:0]    mem_d [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    level_q, level_d;

   logic           overrun_q, overrun_d;
   logic           timeout_q, timeout_d;
   logic           missed_q, missed_d;
   logic [7:0]     miss_cnt_q, miss_cnt_d;

   logic           tick;
   logic           push_req;
   logic           timeout_set;
   logic           miss_set;
   logic           pop;
   logic           full;
   logic           push_ok;
   logic           ovr_set;
   logic [11:0]    push_data;

   // ---------------------------------------------------------------------------
   // Rate counter. A rate_div reprogrammed below the running count wraps
   // without a tick so the next period starts cleanly.
   // ---------------------------------------------------------------------------
   always_comb begin
      div_cnt_d = div_cnt_q;
      tick      = 1'b0;
      if (!enable || (rate_div == 16'd0)) begin
         div_cnt_d = 16'd0;
      end else if (div_cnt_q >= rate_div) begin
         div_cnt_d = 16'd0;
      end else if (div_cnt_q == (rate_div - 16'd1)) begin
         tick      = 1'b1;
         div_cnt_d = 16'd0;
      end else begin
         div_cnt_d = div_cnt_q + 16'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state and counters
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      pulse_cnt_d = pulse_cnt_q;
      to_cnt_d    = to_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d     = S_TRIGGER;
               pulse_cnt_d = PW'(READ_PULSE - 1);
            end
         end
         S_TRIGGER: begin
            if (pulse_cnt_q == '0) begin
               state_d  = S_WAIT_DATA;
               to_cnt_d = '0;
            end else begin
               pulse_cnt_d = pulse_cnt_q - PW'(1);
            end
         end
         S_WAIT_DATA: begin
            if (mic_new_data) begin
               state_d = S_IDLE;
            end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
               state_d = S_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs. mic_read is registered from the next state so it is high
   // exactly for the cycles the FSM spends in TRIGGER.
   // ---------------------------------------------------------------------------
   always_comb begin
      mic_read_d  = (state_d == S_TRIGGER);
      push_req    = (state_q == S_WAIT_DATA) && mic_new_data;
      timeout_set = (state_q == S_WAIT_DATA) && !mic_new_data &&
                    (to_cnt_q == TW'(TIMEOUT - 1));
      miss_set    = tick && (state_q != S_IDLE);
   end

`ifdef MIC_SCHED_SIGNED_EN
   assign push_data = {~mic_audio[11], mic_audio[10:0]};
`else
   assign push_data = mic_audio;
`endif

   // ---------------------------------------------------------------------------
   // FIFO. A push into a full FIFO succeeds only when the head leaves in the
   // same cycle; a pop never happens on an empty FIFO, so push+pop while
   // empty degenerates to a plain push.
   // ---------------------------------------------------------------------------
   always_comb begin
      pop     = (level_q != '0) && sample_ready;
      full    = (level_q == (AW+1)'(DEPTH));
      push_ok = push_req && (!full || pop);
      ovr_set = push_req && full && !pop;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop) begin
         level_d = level_q + (AW+1)'(1);
      end else if (!push_ok && pop) begin
         level_d = level_q - (AW+1)'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Sticky status. A set in the same cycle as clear_status wins; for the
   // counter this means the clear happens first and the new miss counts.
   // ---------------------------------------------------------------------------
   always_comb begin
      overrun_d  = ovr_set     ? 1'b1 : (clear_status ? 1'b0 : overrun_q);
      timeout_d  = timeout_set ? 1'b1 : (clear_status ? 1'b0 : timeout_q);
      missed_d   = miss_set    ? 1'b1 : (clear_status ? 1'b0 : missed_q);
      miss_cnt_d = clear_status ? 8'd0 : miss_cnt_q;
      if (miss_set && (miss_cnt_d != 8'hFF)) begin
         miss_cnt_d = miss_cnt_d + 8'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         div_cnt_q   <= 16'd0;
         pulse_cnt_q <= '0;
         to_cnt_q    <= '0;
         mic_read_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 12'd0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
         missed_q    <= 1'b0;
         miss_cnt_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         to_cnt_q    <= to_cnt_d;
         mic_read_q  <= mic_read_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overrun_q   <= overrun_d;
         timeout_q   <= timeout_d;
         missed_q    <= missed_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   assign mic_read     = mic_read_q;
   assign sample_data  = mem_q[rd_ptr_q];
   assign sample_valid = (level_q != '0);
   assign fifo_level   = level_q;
   assign overrun      = overrun_q;
   assign timeout      = timeout_q;
   assign missed       = missed_q;
   assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_mic_sample_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mic_sample_scheduler
//
// Directed bench for mic_sample_scheduler. A behavioural microphone answers
// each mic_read with mic_new_data after a fixed delay, taking its sample
// values from mic_q. The stimulus pushes the sample each conversion is
// expected to deliver into exp_q; a separate monitor pops and compares on
// every output handshake. Directed checks cover flags, levels and timing.
// -----------------------------------------------------------------------------
module tb_mic_sample_scheduler;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk;
   logic          rst;
   logic          enable;
   logic [15:0]   rate_div;
   logic          clear_status;
   logic          mic_read;
   logic          mic_new_data;
   logic [11:0]   mic_audio;
   logic [11:0]   sample_data;
   logic          sample_valid;
   logic          sample_ready;
   logic [AW:0]   fifo_level;
   logic          overrun;
   logic          timeout;
   logic          missed;
   logic [7:0]    miss_cnt;

   int            tests_run    = 0;
   int            tests_failed = 0;

   logic [11:0]   exp_q[$];
   logic [11:0]   mic_q[$];
   bit            mic_on     = 1'b1;
   int            mic_delay  = 10;
   int            ready_mode = 0;   // 0: low, 1: high, 2: high only with new_data

   mic_sample_scheduler #(
      .DEPTH      (DEPTH),
      .READ_PULSE (2),
      .TIMEOUT    (4096)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .rate_div     (rate_div),
      .clear_status (clear_status),
      .mic_read     (mic_read),
      .mic_new_data (mic_new_data),
      .mic_audio    (mic_audio),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .fifo_level   (fifo_level),
      .overrun      (overrun),
      .timeout      (timeout),
      .missed       (missed),
      .miss_cnt     (miss_cnt)
   );

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- helpers
   function automatic logic [11:0] conv(input logic [11:0] v);
`ifdef MIC_SCHED_SIGNED_EN
      return {~v[11], v[10:0]};
`else
      return v;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1 clear_status = 1'b1;
      @(posedge clk); #1 clear_status = 1'b0;
   endtask

   task automatic wait_rise(input int limit, output int k, output bit ok);
      k  = 0;
      ok = 1'b0;
      while (k < limit) begin
         @(negedge clk);
         k++;
         if (mic_read) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic count_reads(input int n, output int c);
      c = 0;
      repeat (n) begin
         @(negedge clk);
         if (mic_read) c++;
      end
   endtask

   task automatic wait_drain(input string name, input int limit);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < limit) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      check(name, exp_q.size(), 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_mic_read"},     mic_read,     0);
      check({tag, "_sample_valid"}, sample_valid, 0);
      check({tag, "_sample_data"},  sample_data,  0);
      check({tag, "_fifo_level"},   fifo_level,   0);
      check({tag, "_overrun"},      overrun,      0);
      check({tag, "_timeout"},      timeout,      0);
      check({tag, "_missed"},       missed,       0);
      check({tag, "_miss_cnt"},     miss_cnt,     0);
   endtask

   // ---------------------------------------------------------------- mic model / ready driver
   initial begin
      int   cnt;
      logic prev;
      cnt          = -1;
      prev         = 1'b0;
      mic_new_data = 1'b0;
      mic_audio    = 12'd0;
      sample_ready = 1'b0;
      forever begin
         @(negedge clk);
         mic_new_data = 1'b0;
         sample_ready = (ready_mode == 1);
         if (cnt == 0) begin
            if (mic_q.size() > 0) begin
               mic_new_data = 1'b1;
               mic_audio    = mic_q.pop_front();
               if (ready_mode == 2) sample_ready = 1'b1;
            end
            cnt = -1;
         end else if (cnt > 0) begin
            cnt--;
         end
         if (mic_on && mic_read && !prev) cnt = mic_delay;
         prev = mic_read;
      end
   end

   // ---------------------------------------------------------------- scoreboard monitor
   initial begin
      logic [11:0] exp;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && sample_valid && sample_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL sample_unexpected: got %0h, required no sample", sample_data);
            end else begin
               exp = exp_q.pop_front();
               if (sample_data !== exp) begin
                  tests_failed++;
                  $display("FAIL sample_data: got %0h, required %0h", sample_data, exp);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- watchdog
   initial begin
      #1000000;
      tests_failed++;
      $display("FAIL watchdog: run not complete, required finish before time limit");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int k;
      int w;
      int c;
      bit ok;

      rst          = 1'b1;
      enable       = 1'b0;
      rate_div     = 16'd0;
      clear_status = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");

      // Periodic sampling: 2-cycle strobe every 200 cycles.
      ready_mode = 1;
      mic_q.push_back(12'hCDE); exp_q.push_back(conv(12'hCDE));
      mic_q.push_back(12'h123); exp_q.push_back(conv(12'h123));
      rate_div = 16'd200;
      enable   = 1'b1;
      wait_rise(300, k, ok);
      check("periodic_first_read", ok, 1);
      w = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mic_read) w++;
         else break;
      end
      check("periodic_read_width", w, 2);
      wait_rise(300, k, ok);
      check("periodic_second_read", ok, 1);
      check("periodic_period", w + k, 200);
      enable = 1'b0;
      wait_drain("periodic_drain", 100);
      check("periodic_overrun", overrun, 0);
      check("periodic_timeout", timeout, 0);
      check("periodic_missed", missed, 0);

      // Overrun: 9 conversions into a stalled 8-deep FIFO.
      ready_mode = 0;
      rate_div   = 16'd30;
      for (int i = 1; i <= 9; i++) begin
         mic_q.push_back(12'h100 + 12'(i));
         if (i <= 8) exp_q.push_back(conv(12'h100 + 12'(i)));
      end
      @(posedge clk); #1 enable = 1'b1;
      repeat (285) @(posedge clk);
      #1 enable = 1'b0;
      repeat (30) @(negedge clk);
      check("overrun_level", fifo_level, 8);
      check("overrun_flag", overrun, 1);
      check("overrun_head", sample_data, conv(12'h101));
      pulse_clear();
      @(negedge clk);
      check("overrun_cleared", overrun, 0);
      ready_mode = 1;
      wait_drain("overrun_drain", 50);
      check("overrun_level_empty", fifo_level, 0);

      // Backpressure: fill, hold, then push and pop together while full.
      ready_mode = 0;
      for (int i = 1; i <= 8; i++) begin
         mic_q.push_back(12'h200 + 12'(i));
         exp_q.push_back(conv(12'h200 + 12'(i)));
      end
      @(posedge clk); #1 enable = 1'b1;
      repeat (255) @(posedge clk);
      #1 enable = 1'b0;
      repeat (30) @(negedge clk);
      check("bp_full_level", fifo_level, 8);
      check("bp_head_hold_a", sample_data, conv(12'h201));
      repeat (10) @(negedge clk);
      check("bp_head_hold_b", sample_data, conv(12'h201));
      check("bp_valid_hold", sample_valid, 1);
      mic_q.push_back(12'h2FF);
      exp_q.push_back(conv(12'h2FF));
      ready_mode = 2;
      @(posedge clk); #1 enable = 1'b1;
      repeat (40) @(posedge clk);
      #1 enable = 1'b0;
      repeat (30) @(negedge clk);
      check("bp_level_after_pushpop", fifo_level, 8);
      check("bp_no_overrun", overrun, 0);
      check("bp_new_head", sample_data, conv(12'h202));
      ready_mode = 1;
      wait_drain("bp_drain", 50);
      check("bp_level_empty", fifo_level, 0);

      // rate_div = 0: no reads while enabled.
      rate_div = 16'd0;
      enable   = 1'b1;
      count_reads(1000, c);
      check("rate0_no_reads", c, 0);
      enable = 1'b0;

      // enable dropped in TRIGGER: sample still captured, no more reads.
      rate_div = 16'd50;
      mic_q.push_back(12'h0F0);
      exp_q.push_back(conv(12'h0F0));
      enable = 1'b1;
      wait_rise(100, k, ok);
      check("endrop_read", ok, 1);
      enable = 1'b0;
      count_reads(150, c);
      check("endrop_read_cycles", c, 1);
      wait_drain("endrop_drain", 10);

      // Reset during WAIT_DATA; the late new_data must be ignored.
      mic_q.push_back(12'h555);
      enable = 1'b1;
      wait_rise(100, k, ok);
      check("rstwait_read", ok, 1);
      enable = 1'b0;
      repeat (5) @(negedge clk);
      do_reset();
      repeat (20) @(negedge clk);
      check("rstwait_mic_q_used", mic_q.size(), 0);
      check_idle_outputs("rstwait");
      mic_q.push_back(12'h3A5);
      exp_q.push_back(conv(12'h3A5));
      enable = 1'b1;
      wait_rise(100, k, ok);
      check("rstwait_fresh_read", ok, 1);
      enable = 1'b0;
      wait_drain("rstwait_fresh_drain", 50);

      // Timeout with missed ticks: 40 misses before the 4096-cycle abort.
      pulse_clear();
      mic_on   = 1'b0;
      rate_div = 16'd100;
      enable   = 1'b1;
      k = 0;
      while (!timeout && k < 5000) begin
         @(negedge clk);
         k++;
      end
      check("to_timeout_set", timeout, 1);
      check("to_missed_set", missed, 1);
      check("to_miss_cnt", miss_cnt, 40);
      check("to_no_sample", sample_valid, 0);
      wait_rise(5, k, ok);
      check("to_retrigger", ok, 1);
      enable = 1'b0;
      do_reset();
      mic_on = 1'b1;
      @(negedge clk);
      check("to_reset_timeout", timeout, 0);
      check("to_reset_miss_cnt", miss_cnt, 0);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
